// File: rtl/gin_issue_fifo.sv
// -----------------------------------------------------------------------------
// gin_issue_fifo
//   Issue stage feeding one GIN X-bus. (tag, value) packets arrive from the
//   global-buffer side over a valid/ready handshake and wait in a DEPTH-entry
//   FIFO. The head entry is presented on the bus as {enable, tag, value}. It is
//   popped in any cycle where the bus reports ready, which is the AND of all PE
//   ready lines. Two saturating counters record issued packets and stalled
//   cycles for performance debug.
//
// Ports
//   clk                   rising-edge clock for all state
//   rst                   synchronous, active-high reset
//   in_valid / in_ready   producer handshake; a push happens when both are 1
//   in_tag / in_value     packet multicast tag and payload
//   bus_ready             X-bus ready; pops the head when enable=1
//   bus_enable_tag_value  {enable, tag, value}; all zeros while the FIFO is empty
//   flush                 synchronous queue clear; the debug counters are kept
//   count / empty         current occupancy
//   issued_cnt            packets accepted by the bus (saturating)
//   stall_cnt             cycles with enable=1 and bus_ready=0 (saturating)
// -----------------------------------------------------------------------------
module gin_issue_fifo #(
    parameter int ID_LEN    = 5,
    parameter int VALUE_LEN = 32,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ID_LEN-1:0]             in_tag,
    input  logic [VALUE_LEN-1:0]          in_value,
    input  logic                          bus_ready,
    output logic [VALUE_LEN+ID_LEN:0]     bus_enable_tag_value,
    input  logic                          flush,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          empty,
    output logic [CNT_W-1:0]              issued_cnt,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = ID_LEN + VALUE_LEN;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Storage: one {tag, value} word per entry.
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] stall_q,  stall_d;

    logic is_empty;
    logic is_full;
    logic enable;
    logic push;
    logic pop;
    logic stall;

    // Full and empty come from the occupancy count. The pointers are plain
    // wrapping indices and cannot tell full from empty by themselves.
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == OCC_FULL);
    assign enable   = !is_empty;

    // in_ready does not depend on bus_ready. A full FIFO refuses a push even
    // when a pop happens in the same cycle. This keeps the ready path short.
    assign in_ready = !rst && !flush && !is_full;

    assign push  = in_valid && in_ready;
    assign pop   = enable && bus_ready;
    assign stall = enable && !bus_ready && !flush;

    // The bus word is built from registered state only. There is no
    // write-through bypass, so a packet pushed into an empty FIFO is first
    // seen on the bus in the next cycle.
    always_comb begin
        bus_enable_tag_value = '0;
        if (enable) begin
            bus_enable_tag_value = {1'b1, mem_q[rd_ptr_q]};
        end
    end

    assign count      = count_q;
    assign empty      = is_empty;
    assign issued_cnt = issued_q;
    assign stall_cnt  = stall_q;

    // Next-state logic for the pointers, occupancy and debug counters.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        issued_d = issued_q;
        stall_d  = stall_q;

        if (flush) begin
            // Drop every queued entry. A pop in this cycle is not counted,
            // and the history counters are left as they are.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase

            if (pop && (issued_q != CNT_MAX)) begin
                issued_d = issued_q + CNT_W'(1);
            end
            if (stall && (stall_q != CNT_MAX)) begin
                stall_d = stall_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    // Entry storage is not reset. An entry is only read after a push has
    // written it. push already excludes rst and flush through in_ready.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_tag, in_value};
        end
    end

endmodule

// File: tb/tb_gin_issue_fifo.sv
module tb_gin_issue_fifo;

    localparam int ID_LEN    = 5;
    localparam int VALUE_LEN = 32;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    logic [ID_LEN-1:0]          in_tag;
    logic [VALUE_LEN-1:0]       in_value;
    logic                       bus_ready;
    logic [VALUE_LEN+ID_LEN:0]  bus_word;
    logic                       flush;
    logic [2:0]                 count;
    logic                       empty;
    logic [CNT_W-1:0]           issued_cnt;
    logic [CNT_W-1:0]           stall_cnt;

    int errors = 0;
    int checks = 0;

    gin_issue_fifo #(
        .ID_LEN   (ID_LEN),
        .VALUE_LEN(VALUE_LEN),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_tag              (in_tag),
        .in_value            (in_value),
        .bus_ready           (bus_ready),
        .bus_enable_tag_value(bus_word),
        .flush               (flush),
        .count               (count),
        .empty               (empty),
        .issued_cnt          (issued_cnt),
        .stall_cnt           (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- vectors
    // Each row holds the inputs for one cycle and the outputs expected just
    // before that cycle's clock edge.
    typedef struct {
        logic        vld;
        logic [4:0]  tag;
        logic [31:0] val;
        logic        br;
        logic        fl;
        logic        e_en;
        logic [4:0]  e_tag;
        logic [31:0] e_val;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic [3:0]  e_iss;
        logic [3:0]  e_st;
    } vec_t;

    localparam int NVEC = 28;
    vec_t tbl [NVEC];

    function automatic vec_t v(input logic vld, input logic [4:0] tag, input logic [31:0] val,
                               input logic br, input logic fl, input logic e_en,
                               input logic [4:0] e_tag, input logic [31:0] e_val,
                               input logic [2:0] e_cnt, input logic e_rdy,
                               input logic [3:0] e_iss, input logic [3:0] e_st);
        vec_t r;
        r.vld = vld; r.tag = tag; r.val = val; r.br = br; r.fl = fl;
        r.e_en = e_en; r.e_tag = e_tag; r.e_val = e_val; r.e_cnt = e_cnt;
        r.e_rdy = e_rdy; r.e_iss = e_iss; r.e_st = e_st;
        return r;
    endfunction

    // ------------------------------------------------------- reference model
    logic [ID_LEN+VALUE_LEN-1:0] mq[$];
    int m_iss;
    int m_st;

    task automatic model_check(input int cyc);
        logic [VALUE_LEN+ID_LEN:0] w;
        w = '0;
        if (mq.size() > 0) w = {1'b1, mq[0]};
        check($sformatf("rnd%0d_word", cyc), 64'(bus_word), 64'(w));
        check($sformatf("rnd%0d_count", cyc), 64'(count), 64'(mq.size()));
        check($sformatf("rnd%0d_empty", cyc), 64'(empty), 64'(mq.size() == 0));
        check($sformatf("rnd%0d_in_ready", cyc), 64'(in_ready),
              64'(!rst && !flush && mq.size() < DEPTH));
        check($sformatf("rnd%0d_issued", cyc), 64'(issued_cnt), 64'(m_iss));
        check($sformatf("rnd%0d_stall", cyc), 64'(stall_cnt), 64'(m_st));
    endtask

    // Applies the rules for one clock edge, using the inputs that are
    // currently driven.
    task automatic model_step();
        int  sz;
        bit  can_push;
        sz = mq.size();
        can_push = in_valid && !rst && !flush && (sz < DEPTH);
        if (rst) begin
            mq.delete();
            m_iss = 0;
            m_st  = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (sz > 0 && !bus_ready && m_st < CNT_MAX) m_st++;
            if (sz > 0 && bus_ready) begin
                void'(mq.pop_front());
                if (m_iss < CNT_MAX) m_iss++;
            end
            if (can_push) mq.push_back({in_tag, in_value});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_tag = '0; in_value = '0;
        bus_ready = 1'b0; flush = 1'b0;

        tbl[0]  = v(1, 5'h03, 32'hDEADBEEF, 1, 0, 0, 5'h00, 32'h0,        0, 1, 0, 0);
        tbl[1]  = v(0, 5'h00, 32'h0,        1, 0, 1, 5'h03, 32'hDEADBEEF, 1, 1, 0, 0);
        tbl[2]  = v(0, 5'h00, 32'h0,        0, 0, 0, 5'h00, 32'h0,        0, 1, 1, 0);
        tbl[3]  = v(1, 5'h01, 32'h101,      0, 0, 0, 5'h00, 32'h0,        0, 1, 1, 0);
        tbl[4]  = v(1, 5'h02, 32'h102,      0, 0, 1, 5'h01, 32'h101,      1, 1, 1, 0);
        tbl[5]  = v(1, 5'h03, 32'h103,      0, 0, 1, 5'h01, 32'h101,      2, 1, 1, 1);
        tbl[6]  = v(1, 5'h04, 32'h104,      0, 0, 1, 5'h01, 32'h101,      3, 1, 1, 2);
        tbl[7]  = v(1, 5'h05, 32'h105,      0, 0, 1, 5'h01, 32'h101,      4, 0, 1, 3);
        tbl[8]  = v(0, 5'h00, 32'h0,        1, 0, 1, 5'h01, 32'h101,      4, 0, 1, 4);
        tbl[9]  = v(0, 5'h00, 32'h0,        1, 0, 1, 5'h02, 32'h102,      3, 1, 2, 4);
        tbl[10] = v(0, 5'h00, 32'h0,        1, 0, 1, 5'h03, 32'h103,      2, 1, 3, 4);
        tbl[11] = v(0, 5'h00, 32'h0,        1, 0, 1, 5'h04, 32'h104,      1, 1, 4, 4);
        tbl[12] = v(0, 5'h00, 32'h0,        0, 0, 0, 5'h00, 32'h0,        0, 1, 5, 4);
        tbl[13] = v(1, 5'h06, 32'h106,      0, 0, 0, 5'h00, 32'h0,        0, 1, 5, 4);
        tbl[14] = v(1, 5'h07, 32'h107,      0, 0, 1, 5'h06, 32'h106,      1, 1, 5, 4);
        tbl[15] = v(1, 5'h08, 32'h108,      1, 0, 1, 5'h06, 32'h106,      2, 1, 5, 5);
        tbl[16] = v(0, 5'h00, 32'h0,        1, 0, 1, 5'h07, 32'h107,      2, 1, 6, 5);
        tbl[17] = v(0, 5'h00, 32'h0,        1, 0, 1, 5'h08, 32'h108,      1, 1, 7, 5);
        tbl[18] = v(0, 5'h00, 32'h0,        0, 0, 0, 5'h00, 32'h0,        0, 1, 8, 5);
        tbl[19] = v(1, 5'h09, 32'h109,      0, 0, 0, 5'h00, 32'h0,        0, 1, 8, 5);
        tbl[20] = v(1, 5'h0A, 32'h10A,      0, 0, 1, 5'h09, 32'h109,      1, 1, 8, 5);
        tbl[21] = v(1, 5'h0B, 32'h10B,      0, 0, 1, 5'h09, 32'h109,      2, 1, 8, 6);
        tbl[22] = v(1, 5'h0C, 32'h10C,      0, 1, 1, 5'h09, 32'h109,      3, 0, 8, 7);
        tbl[23] = v(1, 5'h0D, 32'h10D,      1, 0, 0, 5'h00, 32'h0,        0, 1, 8, 7);
        tbl[24] = v(0, 5'h00, 32'h0,        1, 0, 1, 5'h0D, 32'h10D,      1, 1, 8, 7);
        tbl[25] = v(1, 5'h0E, 32'h10E,      0, 0, 0, 5'h00, 32'h0,        0, 1, 9, 7);
        tbl[26] = v(0, 5'h00, 32'h0,        1, 1, 1, 5'h0E, 32'h10E,      1, 0, 9, 7);
        tbl[27] = v(0, 5'h00, 32'h0,        0, 0, 0, 5'h00, 32'h0,        0, 1, 9, 7);

        // Reset held for 3 cycles, then released.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready_low", 64'(in_ready), 64'(0));
        check("rst_word", 64'(bus_word), 64'(0));
        rst = 1'b0;
        #1;
        check("rel_word", 64'(bus_word), 64'(0));
        check("rel_empty", 64'(empty), 64'(1));
        check("rel_count", 64'(count), 64'(0));
        check("rel_in_ready", 64'(in_ready), 64'(1));
        check("rel_issued", 64'(issued_cnt), 64'(0));
        check("rel_stall", 64'(stall_cnt), 64'(0));
        tick();

        // Directed vectors: single issue, fill and stall, push with pop, flush.
        for (int i = 0; i < NVEC; i++) begin
            in_valid  = tbl[i].vld;
            in_tag    = tbl[i].tag;
            in_value  = tbl[i].val;
            bus_ready = tbl[i].br;
            flush     = tbl[i].fl;
            #1;
            $display("vec %0d: vld=%0b tag=%h br=%0b fl=%0b -> word=%h cnt=%0d rdy=%0b iss=%0d st=%0d",
                     i, in_valid, in_tag, bus_ready, flush, bus_word, count, in_ready,
                     issued_cnt, stall_cnt);
            check($sformatf("vec%0d_word", i), 64'(bus_word),
                  64'({tbl[i].e_en, tbl[i].e_tag, tbl[i].e_val}));
            check($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
            check($sformatf("vec%0d_empty", i), 64'(empty), 64'(tbl[i].e_cnt == 0));
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
            check($sformatf("vec%0d_issued", i), 64'(issued_cnt), 64'(tbl[i].e_iss));
            check($sformatf("vec%0d_stall", i), 64'(stall_cnt), 64'(tbl[i].e_st));
            tick();
        end

        // issued_cnt saturation: 20 packets streamed back to back.
        in_valid = 1'b0; bus_ready = 1'b0; flush = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 21; i++) begin
            in_valid  = (i < 20);
            in_tag    = 5'(i);
            in_value  = 32'(i) + 32'h200;
            bus_ready = 1'b1;
            #1;
            if (i == 14) check("sat_issued_14", 64'(issued_cnt), 64'(13));
            tick();
        end
        in_valid = 1'b0; bus_ready = 1'b0;
        #1;
        $display("sat issued: issued=%0d empty=%0b", issued_cnt, empty);
        check("sat_issued_15", 64'(issued_cnt), 64'(15));
        check("sat_empty", 64'(empty), 64'(1));
        check("sat_no_stall", 64'(stall_cnt), 64'(0));

        // stall_cnt saturation: one packet held for 20 cycles.
        in_valid = 1'b1; in_tag = 5'h1F; in_value = 32'hCAFE0001;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        #1;
        $display("sat stall: stall=%0d word=%h", stall_cnt, bus_word);
        check("sat_stall_15", 64'(stall_cnt), 64'(15));
        check("hold_word", 64'(bus_word), 64'({1'b1, 5'h1F, 32'hCAFE0001}));

        // Reset while a packet is pending.
        rst = 1'b1;
        tick();
        check("midrst_word", 64'(bus_word), 64'(0));
        check("midrst_count", 64'(count), 64'(0));
        check("midrst_issued", 64'(issued_cnt), 64'(0));
        check("midrst_stall", 64'(stall_cnt), 64'(0));
        rst = 1'b0;

        // Random traffic against the queue model.
        mq.delete();
        m_iss = 0;
        m_st  = 0;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_tag    = 5'($urandom);
            in_value  = $urandom;
            bus_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 99) < 4);
            rst       = ($urandom_range(0, 99) < 2);
            #1;
            $display("rnd %0d: vld=%0b br=%0b fl=%0b rst=%0b word=%h cnt=%0d",
                     c, in_valid, bus_ready, flush, rst, bus_word, count);
            model_check(c);
            model_step();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
